// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings, default busy lengths, decode helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a; the hazard unit and decoder import the same encodings.
package mdu_pkg;

    typedef logic [3:0] mdu_op_t;

    // MDUOp encodings; 9..15 decode as NONE everywhere
    localparam mdu_op_t MDU_NONE  = 4'd0;
    localparam mdu_op_t MDU_MULT  = 4'd1;
    localparam mdu_op_t MDU_MULTU = 4'd2;
    localparam mdu_op_t MDU_DIV   = 4'd3;
    localparam mdu_op_t MDU_DIVU  = 4'd4;
    localparam mdu_op_t MDU_MFHI  = 4'd5;
    localparam mdu_op_t MDU_MFLO  = 4'd6;
    localparam mdu_op_t MDU_MTHI  = 4'd7;
    localparam mdu_op_t MDU_MTLO  = 4'd8;

    // Default busy lengths
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Busy counter width; comfortably covers any realistic cycle count
    localparam int CNT_W = 16;

    // Architectural HI/LO pair as a single 64-bit word
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // True for ops that start a multi-cycle operation
    function automatic logic is_muldiv(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // True for divide ops (select DIV_CYCLES and divide-by-zero handling)
    function automatic logic is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // True for any op the MDU owns (the hazard unit stalls these while busy)
    function automatic logic is_mdu(input mdu_op_t op);
        return (op >= MDU_MULT) && (op <= MDU_MTLO);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage MDU bundle: operation/operands in, start/busy/read data out.
// Latency: n/a (wires only).
// Backpressure: MDU_busy/MDU_start tell the hazard unit to stall D.
interface mdu_if;
    import mdu_pkg::*;

    mdu_op_t     MDUOp_E;
    logic [31:0] SrcA_E;
    logic [31:0] SrcB_E;
    logic        MDU_start;
    logic        MDU_busy;
    logic [31:0] MDUOut_E;

    // Pipeline side: drives the instruction, observes status and read data
    modport master (
        output MDUOp_E, SrcA_E, SrcB_E,
        input  MDU_start, MDU_busy, MDUOut_E
    );

    // MDU side
    modport slave (
        input  MDUOp_E, SrcA_E, SrcB_E,
        output MDU_start, MDU_busy, MDUOut_E
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath producing {hi, lo} and a divide-by-zero flag.
// Latency: 0 cycles (result is latched by mdu at start and held pending).
// Backpressure: none; evaluated every cycle, used only when a start is accepted.
module mdu_arith
    import mdu_pkg::*;
(
    input  mdu_op_t     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output hilo_t       res_o,
    output logic        div_by_zero_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        b_zero;

    // Multipliers: sign- and zero-extended 64-bit products
    always_comb begin
        prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        prod_u = {32'd0, a_i} * {32'd0, b_i};
    end

    // One unsigned divider shared by DIV (on magnitudes) and DIVU (on raw operands).
    // A zero divisor is replaced by 1 so the result is defined; it is discarded anyway.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negated is itself.
    always_comb begin
        b_zero = (b_i == 32'd0);
        abs_a  = a_i[31] ? (32'd0 - a_i) : a_i;
        abs_b  = b_i[31] ? (32'd0 - b_i) : b_i;
        div_a  = (op_i == MDU_DIV) ? abs_a : a_i;
        div_b  = (op_i == MDU_DIV) ? abs_b : b_i;
        if (b_zero) begin
            div_b = 32'd1;
        end
        q_mag  = div_a / div_b;
        r_mag  = div_a % div_b;
    end

    // Result select; quotient sign = sign(a)^sign(b), remainder takes sign of dividend
    always_comb begin
        res_o         = '0;
        div_by_zero_o = is_div(op_i) && b_zero;
        case (op_i)
            MDU_MULT:  res_o = prod_s;
            MDU_MULTU: res_o = prod_u;
            MDU_DIV: begin
                res_o.lo = (a_i[31] ^ b_i[31]) ? (32'd0 - q_mag) : q_mag;
                res_o.hi = a_i[31] ? (32'd0 - r_mag) : r_mag;
            end
            MDU_DIVU: begin
                res_o.lo = q_mag;
                res_o.hi = r_mag;
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO, runs mult/div for a fixed busy window, serves mf/mt.
// Latency: start in t -> busy t+1..t+N -> HI/LO updated from t+N+1; mthi/mtlo visible at t+1.
// Backpressure: MDU_start (comb) and MDU_busy (reg) stall D-stage MDU ops; ops while busy are ignored.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;

    logic             start;
    hilo_t            arith_res;
    logic             arith_dz;

    mdu_arith u_arith (
        .op_i          (bus.MDUOp_E),
        .a_i           (bus.SrcA_E),
        .b_i           (bus.SrcB_E),
        .res_o         (arith_res),
        .div_by_zero_o (arith_dz)
    );

    // A mult/div is accepted only when nothing is in flight
    always_comb begin
        start = is_muldiv(bus.MDUOp_E) && !busy_q;
    end

    // Next-state: start loads counter and pending result; count-down commits on 1->0; mt writes when idle
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;

        if (start) begin
            cnt_d     = is_div(bus.MDUOp_E) ? DIV_LOAD : MULT_LOAD;
            pend_hi_d = arith_res.hi;
            pend_lo_d = arith_res.lo;
            pend_dz_d = arith_dz;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            // A divide by zero leaves the architectural HI/LO untouched
            if ((cnt_q == CNT_W'(1)) && !pend_dz_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end

        if (!busy_q && (bus.MDUOp_E == MDU_MTHI)) begin
            hi_d = bus.SrcA_E;
        end
        if (!busy_q && (bus.MDUOp_E == MDU_MTLO)) begin
            lo_d = bus.SrcA_E;
        end

        busy_d = (cnt_d != '0);
    end

    // State registers; reset discards any in-flight result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_dz_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
        end
    end

    // Outputs: architectural HI/LO only, so pending results never leak early
    always_comb begin
        bus.MDU_start = start;
        bus.MDU_busy  = busy_q;
        case (bus.MDUOp_E)
            MDU_MFHI: bus.MDUOut_E = hi_q;
            MDU_MFLO: bus.MDUOut_E = lo_q;
            default:  bus.MDUOut_E = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: directed test-plan cases plus randomized op streams.
// Driver pushes expected read data from an architectural HI/LO model; monitor checks at negedge.
// Stimulus never issues MDU ops while busy (as the hazard unit guarantees).
module tb_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;

    mdu_if bus ();

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Architectural model state
    logic [31:0] m_hi, m_lo;
    logic [31:0] p_hi, p_lo;
    logic        p_vld, p_dz;
    int          p_commit;
    int          busy_start, busy_end;
    int          cyc;
    logic [31:0] exp_q[$];

    int n_checks;
    int n_err;
    logic mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic from plain 64-bit integer math: returns {hi, lo}
    function automatic logic [63:0] ref_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, t, q64, r64;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        t  = '0;
        case (op)
            MDU_MULT:  t = sa * sb;
            MDU_MULTU: t = ua * ub;
            MDU_DIV: begin
                sq  = sa / sb;
                sr  = sa % sb;
                q64 = sq;
                r64 = sr;
                t   = {r64[31:0], q64[31:0]};
            end
            MDU_DIVU: begin
                q64 = ua / ub;
                r64 = ua % ub;
                t   = {r64[31:0], q64[31:0]};
            end
            default: t = '0;
        endcase
        return t;
    endfunction

    // Present one instruction in E for one cycle and update the model
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int          n;
        @(posedge clk);
        #1;
        cyc++;
        if (p_vld && (cyc >= p_commit)) begin
            if (!p_dz) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
            p_vld = 1'b0;
        end
        bus.MDUOp_E = op;
        bus.SrcA_E  = a;
        bus.SrcB_E  = b;
        case (op)
            MDU_MFHI: exp_q.push_back(m_hi);
            MDU_MFLO: exp_q.push_back(m_lo);
            MDU_MTHI: m_hi = a;
            MDU_MTLO: m_lo = a;
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                n = ((op == MDU_DIV) || (op == MDU_DIVU)) ? DC : MC;
                p_dz = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);
                if (!p_dz) begin
                    r    = ref_calc(op, a, b);
                    p_hi = r[63:32];
                    p_lo = r[31:0];
                end
                p_vld      = 1'b1;
                p_commit   = cyc + n + 1;
                busy_start = cyc;
                busy_end   = cyc + n;
            end
            default: ;
        endcase
    endtask

    // Issue an op; for mult/div fill the busy window with bubbles
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b);
        if (is_muldiv(op)) begin
            repeat (is_div(op) ? DC : MC) drive(MDU_NONE, $urandom, $urandom);
        end
    endtask

    task automatic read_both();
        drive(MDU_MFHI, $urandom, $urandom);
        drive(MDU_MFLO, $urandom, $urandom);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: busy/start every cycle, read data whenever an mf op is presented
    always @(negedge clk) begin
        logic        exp_busy;
        logic [3:0]  op;
        logic [31:0] e;
        if (mon_en) begin
            op       = bus.MDUOp_E;
            exp_busy = (cyc > busy_start) && (cyc <= busy_end);
            check("busy", {31'd0, bus.MDU_busy}, {31'd0, exp_busy});
            check("start", {31'd0, bus.MDU_start}, {31'd0, is_muldiv(op) && !exp_busy});
            if ((op == MDU_MFHI) || (op == MDU_MFLO)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL mf_read: got %08h but no expected value queued", bus.MDUOut_E);
                end else begin
                    e = exp_q.pop_front();
                    check((op == MDU_MFHI) ? "mfhi" : "mflo", bus.MDUOut_E, e);
                end
            end else begin
                check("out_idle", bus.MDUOut_E, 32'd0);
            end
            assert (!(bus.MDU_busy && is_mdu(op)))
                else $error("MDU op %0d presented while busy", op);
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks    = 0;
        n_err       = 0;
        cyc         = 0;
        m_hi        = '0;
        m_lo        = '0;
        p_hi        = '0;
        p_lo        = '0;
        p_vld       = 1'b0;
        p_dz        = 1'b0;
        p_commit    = 0;
        busy_start  = -1;
        busy_end    = -1;
        reset       = 1'b1;
        bus.MDUOp_E = MDU_NONE;
        bus.SrcA_E  = '0;
        bus.SrcB_E  = '0;
        mon_en      = 1'b1;

        // Reset state: reads return 0, not busy
        drive(MDU_MFHI, 32'h1, 32'h2);
        drive(MDU_MFLO, 32'h1, 32'h2);
        drive(MDU_NONE, 32'h0, 32'h0);
        #1 reset = 1'b0;

        // Test-plan directed cases
        run_op(MDU_MULT,  32'hFFFF_FFFF, 32'h0000_0002); read_both();
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002); read_both();
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002); read_both();
        run_op(MDU_DIVU,  32'h0000_0007, 32'h0000_0002); read_both();
        run_op(MDU_MTHI,  32'h1234_5678, 32'h0);
        drive(MDU_MFHI, 32'h0, 32'h0);
        run_op(MDU_DIV,   32'h0000_0005, 32'h0000_0000); read_both();
        run_op(MDU_DIVU,  32'hDEAD_BEEF, 32'h0000_0000); read_both();
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF); read_both();
        run_op(MDU_MTLO,  32'hCAFE_F00D, 32'h0);
        drive(MDU_MFLO, 32'h0, 32'h0);
        // Back-to-back starts at the earliest legal cycle
        run_op(MDU_MULT,  32'h0001_0003, 32'hFFFF_FFFD);
        run_op(MDU_DIVU,  32'hFFFF_FFFF, 32'h0000_0010); read_both();

        // Reset during busy cycle 3 of a MULT
        drive(MDU_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        drive(MDU_NONE, 32'h0, 32'h0);
        drive(MDU_NONE, 32'h0, 32'h0);
        drive(MDU_NONE, 32'h0, 32'h0);
        #1 reset = 1'b1;
        m_hi        = '0;
        m_lo        = '0;
        p_vld       = 1'b0;
        busy_start  = -1;
        busy_end    = -1;
        bus.MDUOp_E = MDU_MFHI;
        exp_q.push_back(32'd0);
        #2 reset = 1'b0;
        drive(MDU_MFLO, 32'h0, 32'h0);
        run_op(MDU_MULT, 32'h0000_0100, 32'h0000_0100); read_both();

        // Randomized op stream
        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            run_op(op, rand_val(), rand_val());
            if (is_muldiv(op) && ($urandom_range(0, 1) == 1)) read_both();
        end
        read_both();
        drive(MDU_NONE, 32'h0, 32'h0);
        drive(MDU_NONE, 32'h0, 32'h0);

        mon_en = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
